// File: rtl/router_in_arbiter_if.sv
// Bundle of source-side handshake and router-input signals for router_in_arbiter.
// master is the arbiter's view; slave is the sources/router environment's view.
interface router_in_arbiter_if;
  logic [2:0] src_req;
  logic [7:0] src_data_0;
  logic [7:0] src_data_1;
  logic [7:0] src_data_2;
  logic [2:0] src_ready;
  logic       busy;
  logic       packet_valid;
  logic [7:0] datain;
  logic [2:0] grant;
  logic       drop_err;

  modport master (
    input  src_req, src_data_0, src_data_1, src_data_2, busy,
    output src_ready, packet_valid, datain, grant, drop_err
  );

  modport slave (
    output src_req, src_data_0, src_data_1, src_data_2, busy,
    input  src_ready, packet_valid, datain, grant, drop_err
  );
endinterface

// File: rtl/router_in_arbiter.sv
// Round-robin 3-source packet arbiter feeding one router input; drops addr=3 packets.
// Define ARB_PARITY_GEN_EN to generate the parity byte locally instead of forwarding it.
module router_in_arbiter (
  input  logic                clk,
  input  logic                reset,
  router_in_arbiter_if.master bus
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] HDR  = 3'd1;
  localparam logic [2:0] PLD  = 3'd2;
  localparam logic [2:0] PAR  = 3'd3;
  localparam logic [2:0] DROP = 3'd4;

  logic [2:0] state;
  logic [2:0] grant_q;
  logic [1:0] rr_ptr;
  logic [5:0] cnt;
  logic [7:0] par;
  logic       drop_q;

  logic [1:0] g_idx;
  logic [7:0] cur;
  logic [1:0] pick_idx;
  logic       bad_addr;

  always_comb begin
    g_idx = 2'd0;
    cur   = 8'h00;
    case (grant_q)
      3'b001: begin g_idx = 2'd0; cur = bus.src_data_0; end
      3'b010: begin g_idx = 2'd1; cur = bus.src_data_1; end
      3'b100: begin g_idx = 2'd2; cur = bus.src_data_2; end
      default: begin g_idx = 2'd0; cur = 8'h00; end
    endcase
  end

  assign bad_addr = (cur[1:0] == 2'b11);

  // Search starts at the source after the last one served.
  always_comb begin
    pick_idx = 2'd0;
    case (rr_ptr)
      2'd0: begin
        if (bus.src_req[1])      pick_idx = 2'd1;
        else if (bus.src_req[2]) pick_idx = 2'd2;
        else                     pick_idx = 2'd0;
      end
      2'd1: begin
        if (bus.src_req[2])      pick_idx = 2'd2;
        else if (bus.src_req[0]) pick_idx = 2'd0;
        else                     pick_idx = 2'd1;
      end
      default: begin
        if (bus.src_req[0])      pick_idx = 2'd0;
        else if (bus.src_req[1]) pick_idx = 2'd1;
        else                     pick_idx = 2'd2;
      end
    endcase
  end

  always_comb begin
    bus.datain       = 8'h00;
    bus.packet_valid = 1'b0;
    bus.src_ready    = 3'b000;
    case (state)
      HDR: begin
        bus.datain = cur;
        if (bad_addr) begin
          bus.src_ready = grant_q;
        end else begin
          bus.packet_valid = 1'b1;
          bus.src_ready    = bus.busy ? 3'b000 : grant_q;
        end
      end
      PLD: begin
        bus.datain       = cur;
        bus.packet_valid = 1'b1;
        bus.src_ready    = bus.busy ? 3'b000 : grant_q;
      end
      PAR: begin
`ifdef ARB_PARITY_GEN_EN
        bus.datain    = par;
`else
        bus.datain    = cur;
        bus.src_ready = bus.busy ? 3'b000 : grant_q;
`endif
      end
      DROP: begin
`ifdef ARB_PARITY_GEN_EN
        bus.src_ready = (cnt != 6'd0) ? grant_q : 3'b000;
`else
        bus.src_ready = grant_q;
`endif
      end
      default: ;
    endcase
  end

  assign bus.grant    = grant_q;
  assign bus.drop_err = drop_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      grant_q <= 3'b000;
      rr_ptr  <= 2'd2;
      cnt     <= 6'd0;
      par     <= 8'h00;
      drop_q  <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.src_req != 3'b000) begin
            grant_q <= 3'b001 << pick_idx;
            state   <= HDR;
          end
        end
        HDR: begin
          if (bad_addr) begin
            cnt    <= cur[7:2];
            drop_q <= 1'b1;
            state  <= DROP;
          end else if (!bus.busy) begin
            cnt   <= cur[7:2];
            par   <= cur;
            state <= (cur[7:2] == 6'd0) ? PAR : PLD;
          end
        end
        PLD: begin
          if (!bus.busy) begin
            cnt <= cnt - 6'd1;
            par <= par ^ cur;
            if (cnt == 6'd1) state <= PAR;
          end
        end
        PAR: begin
          if (!bus.busy) begin
            state   <= IDLE;
            grant_q <= 3'b000;
            rr_ptr  <= g_idx;
          end
        end
        DROP: begin
`ifdef ARB_PARITY_GEN_EN
          if (cnt != 6'd0) cnt <= cnt - 6'd1;
          if (cnt <= 6'd1) begin
            state   <= IDLE;
            grant_q <= 3'b000;
            rr_ptr  <= g_idx;
          end
`else
          // The final cycle here swallows the source's parity byte.
          if (cnt == 6'd0) begin
            state   <= IDLE;
            grant_q <= 3'b000;
            rr_ptr  <= g_idx;
          end else begin
            cnt <= cnt - 6'd1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
